random_range_sampler: RTL and testbench

//  Downstream consumer of the free-running 256-bit random word. Turns it into uniform

---
 rtl/random_range_sampler.sv | 206 ++++++++++++++++++++
 tb/tb_random_range_sampler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/random_range_sampler.sv
// random_range_sampler: turns a free-running RAND_W-bit random word into a
// uniform integer in [0, bound) using masked rejection sampling over OUT_W-bit
// slices, with a bounded fallback after MAX_TRIES rejections.
// Optional build macro RANDOM_SAMPLER_STATS_EN adds rejection statistics ports.
module random_range_sampler #(
    parameter int RAND_W    = 256,
    parameter int OUT_W     = 8,
    parameter int MAX_TRIES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RAND_W-1:0] rand_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OUT_W-1:0]  req_bound,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OUT_W-1:0]  rsp_value,
    output logic              rsp_err,
    output logic              rsp_fallback
`ifdef RANDOM_SAMPLER_STATS_EN
    ,
    output logic [15:0]       rsp_rejects,
    output logic [31:0]       total_rejects
`endif
);

    localparam int NSLICE = RAND_W / OUT_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int TRY_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [RAND_W-1:0]                 word_q, word_d;
    logic [OUT_W-1:0]                  bound_q, bound_d;
    logic [OUT_W-1:0]                  mask_q, mask_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [TRY_W-1:0]                  tries_q, tries_d;
    logic                              req_ready_q, req_ready_d;
    logic                              rsp_valid_q, rsp_valid_d;
    logic [OUT_W-1:0]                  rsp_value_q, rsp_value_d;
    logic                              rsp_err_q, rsp_err_d;
    logic                              rsp_fallback_q, rsp_fallback_d;
    logic [15:0]                       rsp_rejects_q, rsp_rejects_d;
    logic [31:0]                       total_rejects_q, total_rejects_d;

    // Word viewed as an array of slices so the candidate is a plain index
    logic [NSLICE-1:0][OUT_W-1:0]      slices;
    logic [OUT_W-1:0]                  bound_m1;
    logic [OUT_W-1:0]                  mask_calc;
    logic [OUT_W-1:0]                  cand;
    logic                              idx_last;
    logic                              tries_last;

    assign slices     = word_q;
    assign cand       = slices[idx_q] & mask_q;
    assign idx_last   = (idx_q == IDX_W'(NSLICE - 1));
    assign tries_last = (tries_q == TRY_W'(MAX_TRIES - 1));

    // Smallest all-ones mask covering bound-1: smear the top set bit downward
    always_comb begin
        bound_m1  = req_bound - OUT_W'(1);
        mask_calc = '0;
        for (int i = 0; i < OUT_W; i++) begin
            mask_calc = mask_calc | (bound_m1 >> i);
        end
    end

    // Next-state and registered-output computation for the sampler FSM
    always_comb begin
        state_d         = state_q;
        word_d          = word_q;
        bound_d         = bound_q;
        mask_d          = mask_q;
        idx_d           = idx_q;
        tries_d         = tries_q;
        req_ready_d     = req_ready_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_value_d     = rsp_value_q;
        rsp_err_d       = rsp_err_q;
        rsp_fallback_d  = rsp_fallback_q;
        rsp_rejects_d   = rsp_rejects_q;
        total_rejects_d = total_rejects_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    bound_d       = req_bound;
                    word_d        = rand_in;
                    mask_d        = mask_calc;
                    idx_d         = '0;
                    tries_d       = '0;
                    rsp_rejects_d = '0;
                    req_ready_d   = 1'b0;
                    if (req_bound == '0) begin
                        // Empty range: answer immediately with an error
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_value_d = '0;
                    end else begin
                        state_d = ST_SAMPLE;
                    end
                end
            end

            ST_SAMPLE: begin
                if (cand < bound_q) begin
                    rsp_value_d = cand;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    rsp_rejects_d = rsp_rejects_q + 16'd1;
                    if (total_rejects_q != '1) begin
                        total_rejects_d = total_rejects_q + 32'd1;
                    end
                    if (tries_last) begin
                        // mask <= 2*bound-2, so cand-bound always lands below bound
                        rsp_value_d    = cand - bound_q;
                        rsp_fallback_d = 1'b1;
                        rsp_valid_d    = 1'b1;
                        state_d        = ST_RESP;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);
                        if (idx_last) begin
                            idx_d  = '0;
                            word_d = rand_in;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d    = 1'b0;
                    rsp_err_d      = 1'b0;
                    rsp_fallback_d = 1'b0;
                    req_ready_d    = 1'b1;
                    state_d        = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            word_q          <= '0;
            bound_q         <= '0;
            mask_q          <= '0;
            idx_q           <= '0;
            tries_q         <= '0;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_value_q     <= '0;
            rsp_err_q       <= 1'b0;
            rsp_fallback_q  <= 1'b0;
            rsp_rejects_q   <= '0;
            total_rejects_q <= '0;
        end else begin
            state_q         <= state_d;
            word_q          <= word_d;
            bound_q         <= bound_d;
            mask_q          <= mask_d;
            idx_q           <= idx_d;
            tries_q         <= tries_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_value_q     <= rsp_value_d;
            rsp_err_q       <= rsp_err_d;
            rsp_fallback_q  <= rsp_fallback_d;
            rsp_rejects_q   <= rsp_rejects_d;
            total_rejects_q <= total_rejects_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_value    = rsp_value_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_fallback = rsp_fallback_q;

`ifdef RANDOM_SAMPLER_STATS_EN
    assign rsp_rejects   = rsp_rejects_q;
    assign total_rejects = total_rejects_q;
`else
    // Counters have no consumer in this build and are trimmed by synthesis
    logic unused_stats;
    assign unused_stats = ^{rsp_rejects_q, total_rejects_q};
`endif

endmodule

// File: tb/tb_random_range_sampler.sv
// Bench for random_range_sampler: directed scenarios plus randomized requests,
// checked against a slice-by-slice rejection-sampling model.
module tb_random_range_sampler;

    localparam int RW = 256;
    localparam int OW = 8;
    localparam int MT = 64;
    localparam int NS = RW / OW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] rand_in;
    logic          req_valid;
    logic          req_ready;
    logic [OW-1:0] req_bound;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [OW-1:0] rsp_value;
    logic          rsp_err;
    logic          rsp_fallback;
`ifdef RANDOM_SAMPLER_STATS_EN
    logic [15:0]   rsp_rejects;
    logic [31:0]   total_rejects;
`endif

    random_range_sampler #(.RAND_W(RW), .OUT_W(OW), .MAX_TRIES(MT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rand_in      (rand_in),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_bound    (req_bound),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_value    (rsp_value),
        .rsp_err      (rsp_err),
        .rsp_fallback (rsp_fallback)
`ifdef RANDOM_SAMPLER_STATS_EN
        ,
        .rsp_rejects  (rsp_rejects),
        .total_rejects(total_rejects)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // hist[k] is the random word presented at the k-th edge after (and incl.) accept
    logic [RW-1:0] hist [0:255];

    int  exp_val, exp_lat, exp_rej;
    bit  exp_err, exp_fb;
    longint tot_rej = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [RW-1:0] mk_word(input int mode);
        logic [RW-1:0] w;
        logic [7:0]    b;
        w = '0;
        for (int s = 0; s < NS; s++) begin
            if (mode == 0) b = 8'($urandom);
            else if (mode == 1) b = ($urandom_range(0, 99) < 97) ? 8'hFF : 8'($urandom);
            else b = 8'hFF;
            w[s*8 +: 8] = b;
        end
        return w;
    endfunction

    task automatic fill(input int mode);
        for (int k = 0; k < 256; k++) hist[k] = mk_word(mode);
    endtask

    // Reference: walk candidate slices in order; a fresh word is taken every NS tries
    task automatic model(input int b);
        int mask, c, w;
        logic [RW-1:0] word;
        exp_err = 0; exp_fb = 0; exp_val = 0; exp_lat = 0; exp_rej = 0;
        if (b == 0) begin
            exp_err = 1;
            return;
        end
        mask = 0;
        while (mask < b - 1) mask = mask * 2 + 1;
        for (int k = 0; k < MT; k++) begin
            w    = (k / NS) * NS;
            word = hist[w];
            c    = int'(word[(k % NS)*8 +: 8]) & mask;
            if (c < b) begin
                exp_val = c; exp_lat = k + 1; exp_rej = k;
                return;
            end
            if (k == MT - 1) begin
                exp_val = c - b; exp_fb = 1; exp_lat = MT; exp_rej = MT;
            end
        end
    endtask

    // One full request/response, response held off for 'hold' cycles
    task automatic run_txn(input string nm, input int b, input int hold);
        int cnt;
        model(b);
        req_valid = 1'b1;
        req_bound = OW'(b);
        rand_in   = hist[0];
        chk({nm, ".req_ready_pre"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_bound = OW'($urandom);
        chk({nm, ".req_ready_busy"}, 64'(req_ready), 64'd0);
        cnt = 0;
        while (!rsp_valid && cnt < 200) begin
            rand_in = hist[cnt+1];
            @(posedge clk); #1;
            cnt++;
        end
        chk({nm, ".latency"}, 64'(cnt), 64'(exp_lat));
        chk({nm, ".value"}, 64'(rsp_value), 64'(exp_val));
        chk({nm, ".err"}, 64'(rsp_err), 64'(exp_err));
        chk({nm, ".fallback"}, 64'(rsp_fallback), 64'(exp_fb));
`ifdef RANDOM_SAMPLER_STATS_EN
        chk({nm, ".rsp_rejects"}, 64'(rsp_rejects), 64'(exp_rej));
        chk({nm, ".total_rejects"}, 64'(total_rejects), 64'(tot_rej + exp_rej));
`endif
        tot_rej += exp_rej;
        for (int h = 0; h < hold; h++) begin
            rand_in = mk_word(0);
            @(posedge clk); #1;
            chk({nm, ".hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({nm, ".hold_value"}, 64'(rsp_value), 64'(exp_val));
            chk({nm, ".hold_flags"}, 64'({rsp_err, rsp_fallback}), 64'({exp_err, exp_fb}));
            chk({nm, ".hold_ready"}, 64'(req_ready), 64'd0);
        end
        // Handshake edge with a competing request that must not be taken
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_bound = 8'd5;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({nm, ".post_valid"}, 64'(rsp_valid), 64'd0);
        chk({nm, ".post_ready"}, 64'(req_ready), 64'd1);
        chk({nm, ".post_flags"}, 64'({rsp_err, rsp_fallback}), 64'd0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".req_ready"}, 64'(req_ready), 64'd1);
        chk({nm, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({nm, ".rsp_value"}, 64'(rsp_value), 64'd0);
        chk({nm, ".flags"}, 64'({rsp_err, rsp_fallback}), 64'd0);
`ifdef RANDOM_SAMPLER_STATS_EN
        chk({nm, ".stats"}, 64'({rsp_rejects, total_rejects}), 64'd0);
`endif
    endtask

    // Reset in the middle of a request, then confirm nothing leaks out afterwards
    task automatic reset_mid(input string nm, input int cycles, input int b);
        bit seen;
        fill(2);
        req_valid = 1'b1;
        req_bound = OW'(b);
        rand_in   = hist[0];
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (cycles) begin
            rand_in = hist[1];
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk_reset_vals({nm, ".async"});
        tot_rej = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1;
        end
        chk({nm, ".no_stale"}, 64'(seen), 64'd0);
        chk({nm, ".ready_after"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [RW-1:0] w;
        rst_n     = 1'b0;
        rand_in   = '0;
        req_valid = 1'b0;
        req_bound = '0;
        rsp_ready = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // bound=1: mask 0, always a first-slice hit
        fill(0);
        run_txn("bound1", 1, 0);

        // bound=0: error response with no sampling
        fill(0);
        run_txn("bound0", 0, 2);

        // bound=200: first slice rejected, second accepted
        fill(0);
        w = hist[0];
        w[7:0]  = 8'hFE;
        w[15:8] = 8'h10;
        hist[0] = w;
        run_txn("bound200", 200, 1);

        // all 0xFF with bound=129: exhaust tries, fallback gives 255-129
        fill(2);
        run_txn("fallback", 129, 0);

        // reload at the 32nd try: hit lives only in the word seen at that edge
        fill(2);
        w = hist[32];
        w[7:0] = 8'h05;
        hist[32] = w;
        run_txn("reload", 129, 0);

        // response held off for 10 cycles
        fill(0);
        run_txn("hold10", 77, 10);

        reset_mid("rst_sample", 5, 129);
        reset_mid("rst_resp", 3, 0);

        // randomized requests, some biased toward long rejection runs
        for (int t = 0; t < 40; t++) begin
            int b;
            fill($urandom_range(0, 1));
            b = (t % 9 == 0) ? 0 : $urandom_range(1, 255);
            run_txn($sformatf("rand%0d", t), b, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
